fruit_collect_ctrl: RTL and testbench
=====================================

FRUIT_COLLECT_CTRL -- requirements
Module: fruit_collect_ctrl

Interface
REQ-001 Parameter COOLDOWN_FRAMES, default 8: number of frame starts after a report during which collisions are ignored; legal range 1..255.
REQ-002 Parameter SCORE_MAX, default 9999: saturation ceiling of the score accumulator.
REQ-003 Port clk  input  1  system clock; the block has a single clock domain.
REQ-004 Port resetN  input  1  asynchronous active-low reset.
REQ-005 Port startOfFrame  input  1  one-cycle pulse marking the first pixel of each frame.
REQ-006 Port game_active  input  1  high while gameplay runs.
REQ-007 Port clear_score  input  1  synchronous score clear.
REQ-008 Port playerDrawRequest  input  1  player sprite draws the current pixel.
REQ-009 Port fruitDrawRequest  input  1  combined fruit draw request from the four-fruit mux.
REQ-010 Port fruit_type  input  8  type of the fruit at the current pixel; 0 means none.
REQ-011 Port fruit_eaten  output  1  one-cycle pulse when a fruit hit is reported.
REQ-012 Port eaten_type  output  8  type of the fruit reported; held until the next report.
REQ-013 Port score  output  16  binary score accumulator.
REQ-014 Port busy  output  1  high whenever the state is not ARMED.

Function
REQ-015 The block SHALL flag a collision in any cycle where playerDrawRequest=1, fruitDrawRequest=1, fruit_type!=0 and game_active=1.
REQ-016 The FSM SHALL have exactly four states: ARMED, HIT, REPORT and COOLDOWN.
REQ-017 In ARMED, a collision SHALL latch fruit_type into an internal type register and move the FSM to HIT on the next edge.
REQ-018 In HIT, further collisions SHALL be ignored, so the first collision pixel of the frame wins.
REQ-019 In HIT, the FSM SHALL move to REPORT on the edge where startOfFrame=1.
REQ-020 If a collision in ARMED coincides with startOfFrame, the FSM SHALL enter HIT and report at the following startOfFrame, not the current one.
REQ-021 In REPORT, which lasts one cycle, the block SHALL:
- assert fruit_eaten=1;
- drive eaten_type with the latched type;
- add the points of REQ-022 to score;
- load the cooldown counter with COOLDOWN_FRAMES;
- enter COOLDOWN.
REQ-022 Points per type SHALL be: type 1 -> 10, type 2 -> 20, type 3 -> 50, any other nonzero type -> 100.
REQ-023 score SHALL saturate at SCORE_MAX: if score+points > SCORE_MAX, score becomes SCORE_MAX.
REQ-024 In COOLDOWN, each startOfFrame SHALL decrement the counter, and the FSM SHALL return to ARMED on the startOfFrame that decrements it from 1 to 0.
REQ-025 Collisions during COOLDOWN SHALL be ignored and SHALL NOT be latched.
REQ-026 When game_active=0, the FSM SHALL go to ARMED on the next edge from any state; a pending HIT is discarded, and score and eaten_type hold.
REQ-027 clear_score=1 SHALL set score to 0 on the next edge.
REQ-028 clear_score SHALL take precedence over a simultaneous REPORT addition; the report pulse and eaten_type still update.
REQ-029 All outputs SHALL be registered, and fruit_eaten SHALL never be high for two consecutive cycles.

Reset
REQ-030 On resetN=0, asynchronously: state=ARMED, fruit_eaten=0, eaten_type=0, score=0, busy=0, cooldown counter=0, latched type=0.
REQ-031 Reset asserted mid-operation (HIT, REPORT or COOLDOWN) SHALL abort with no report pulse.
REQ-032 The first collision after resetN rises SHALL be accepted.

Verification
REQ-033 Basic hit: collision with type 2 mid-frame, then startOfFrame -> on the following cycle fruit_eaten=1 for 1 cycle, eaten_type=2, score 0->20, busy=1.
REQ-034 Multiple collisions in one frame: types 3 then 1 in the same frame -> single report with eaten_type=3, score +50.
REQ-035 Cooldown: COOLDOWN_FRAMES=2, collision in each frame -> report, the next 2 frames ignored, collision accepted again in the 3rd frame after the report.
REQ-036 Saturation: score=9990 preset via hits, then a type-4 hit -> score=9999; a further type-1 hit -> score remains 9999.
REQ-037 Edge cases:
- collision coinciding with startOfFrame -> no report at that frame start, report at the next;
- type-0 collision with both requests high -> no state change.
REQ-038 Abort cases:
- game_active dropped in HIT -> ARMED, no pulse;
- resetN pulsed in COOLDOWN -> all outputs 0 immediately;
- clear_score concurrent with REPORT -> score=0, fruit_eaten=1.

Source files
------------

// File: rtl/fruit_collect_ctrl.sv
// Detects player/fruit collisions, reports the first hit per frame at the next frame start, then ignores hits for a few frames.
// Latency: the report pulse arrives one cycle after the frame start that follows the hit. No backpressure: every report is a single-cycle pulse.
module fruit_collect_ctrl #(
    parameter int COOLDOWN_FRAMES = 8,
    parameter int SCORE_MAX       = 9999
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        startOfFrame,
    input  logic        game_active,
    input  logic        clear_score,
    input  logic        playerDrawRequest,
    input  logic        fruitDrawRequest,
    input  logic [7:0]  fruit_type,
    output logic        fruit_eaten,
    output logic [7:0]  eaten_type,
    output logic [15:0] score,
    output logic        busy
);

    typedef enum logic [1:0] {ARMED, HIT, REPORT, COOLDOWN} state_t;

    state_t      state;
    logic [7:0]  hit_type;
    logic [7:0]  cool_cnt;
    logic        collision;
    logic [7:0]  points;
    logic [16:0] sum;
    logic [15:0] sat_score;

    assign collision = playerDrawRequest && fruitDrawRequest &&
                       (fruit_type != 8'd0) && game_active;

    always_comb begin
        points = 8'd100;
        case (hit_type)
            8'd1:    points = 8'd10;
            8'd2:    points = 8'd20;
            8'd3:    points = 8'd50;
            default: points = 8'd100;
        endcase
    end

    // One spare bit so the saturation compare cannot wrap.
    assign sum       = {1'b0, score} + {9'd0, points};
    assign sat_score = (sum > 17'(SCORE_MAX)) ? 16'(SCORE_MAX) : sum[15:0];

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state       <= ARMED;
            fruit_eaten <= 1'b0;
            eaten_type  <= 8'd0;
            score       <= 16'd0;
            busy        <= 1'b0;
            cool_cnt    <= 8'd0;
            hit_type    <= 8'd0;
        end else begin
            fruit_eaten <= 1'b0;
            if (!game_active) begin
                state    <= ARMED;
                busy     <= 1'b0;
                cool_cnt <= 8'd0;
            end else begin
                case (state)
                    ARMED: begin
                        if (collision) begin
                            hit_type <= fruit_type;
                            state    <= HIT;
                            busy     <= 1'b1;
                        end
                    end
                    HIT: begin
                        // Pulse, type and score are registered on entry so they are visible during REPORT.
                        if (startOfFrame) begin
                            state       <= REPORT;
                            fruit_eaten <= 1'b1;
                            eaten_type  <= hit_type;
                            score       <= sat_score;
                        end
                    end
                    REPORT: begin
                        cool_cnt <= 8'(COOLDOWN_FRAMES);
                        state    <= COOLDOWN;
                    end
                    COOLDOWN: begin
                        if (startOfFrame) begin
                            cool_cnt <= cool_cnt - 8'd1;
                            if (cool_cnt <= 8'd1) begin
                                state <= ARMED;
                                busy  <= 1'b0;
                            end
                        end
                    end
                    default: begin
                        state <= ARMED;
                        busy  <= 1'b0;
                    end
                endcase
            end
            if (clear_score)
                score <= 16'd0;
        end
    end

endmodule

// File: tb/tb_fruit_collect_ctrl.sv
// Self-checking bench for fruit_collect_ctrl: directed scenarios plus random traffic against a frame-level reference model.
module tb_fruit_collect_ctrl;

    localparam int COOL = 2;
    localparam int SMAX = 9999;
    localparam int FL   = 6;

    logic        clk;
    logic        resetN;
    logic        startOfFrame;
    logic        game_active;
    logic        clear_score;
    logic        playerDrawRequest;
    logic        fruitDrawRequest;
    logic [7:0]  fruit_type;
    logic        fruit_eaten;
    logic [7:0]  eaten_type;
    logic [15:0] score;
    logic        busy;

    int tests = 0;
    int fails = 0;

    // Reference model: pending hit, report-in-progress, frames of cooldown left.
    bit m_pending;
    bit m_report;
    int m_cool;
    int m_type;
    int m_score;
    bit m_eaten;
    int m_etype;

    fruit_collect_ctrl #(.COOLDOWN_FRAMES(COOL), .SCORE_MAX(SMAX)) dut (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
        .game_active(game_active), .clear_score(clear_score),
        .playerDrawRequest(playerDrawRequest), .fruitDrawRequest(fruitDrawRequest),
        .fruit_type(fruit_type), .fruit_eaten(fruit_eaten), .eaten_type(eaten_type),
        .score(score), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int pts(input int t);
        case (t)
            1: return 10;
            2: return 20;
            3: return 50;
            default: return 100;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pending = 0; m_report = 0; m_cool = 0; m_type = 0;
        m_score = 0; m_eaten = 0; m_etype = 0;
    endtask

    task automatic model_step(input bit sof, input bit ga, input bit clr,
                              input bit p, input bit f, input int t);
        bit col;
        col = p && f && (t != 0) && ga;
        m_eaten = 0;
        if (!ga) begin
            m_pending = 0; m_report = 0; m_cool = 0;
        end else if (m_report) begin
            m_report = 0;
            m_cool   = COOL;
        end else if (m_cool > 0) begin
            if (sof) m_cool--;
        end else if (m_pending) begin
            if (sof) begin
                m_pending = 0;
                m_report  = 1;
                m_eaten   = 1;
                m_etype   = m_type;
                m_score   = (m_score + pts(m_type) > SMAX) ? SMAX : m_score + pts(m_type);
            end
        end else if (col) begin
            m_pending = 1;
            m_type    = t;
        end
        if (clr) m_score = 0;
    endtask

    task automatic check_model();
        chk("fruit_eaten", {15'd0, fruit_eaten}, {15'd0, m_eaten});
        chk("eaten_type", {8'd0, eaten_type}, 16'(m_etype));
        chk("score", score, 16'(m_score));
        chk("busy", {15'd0, busy}, {15'd0, (m_pending || m_report || m_cool > 0)});
    endtask

    task automatic cyc(input bit sof, input bit ga, input bit clr,
                       input bit p, input bit f, input logic [7:0] t);
        @(negedge clk);
        startOfFrame = sof; game_active = ga; clear_score = clr;
        playerDrawRequest = p; fruitDrawRequest = f; fruit_type = t;
        @(posedge clk);
        model_step(sof, ga, clr, p, f, int'(t));
        #1;
        check_model();
    endtask

    // Cycles 1..FL-1 of a frame, with up to two collision pixels.
    task automatic frame_tail(input logic [7:0] t1, input int p1,
                              input logic [7:0] t2, input int p2);
        for (int i = 1; i < FL; i++) begin
            if (t1 != 0 && i == p1)      cyc(0, 1, 0, 1, 1, t1);
            else if (t2 != 0 && i == p2) cyc(0, 1, 0, 1, 1, t2);
            else                         cyc(0, 1, 0, 0, 0, 8'd0);
        end
    endtask

    task automatic frame(input logic [7:0] t1, input int p1,
                         input logic [7:0] t2, input int p2);
        if (t1 != 0 && p1 == 0) cyc(1, 1, 0, 1, 1, t1);
        else                    cyc(1, 1, 0, 0, 0, 8'd0);
        frame_tail(t1, p1, t2, p2);
    endtask

    task automatic report_chk(input logic [7:0] et, input logic [15:0] sc);
        cyc(1, 1, 0, 0, 0, 8'd0);
        chk("report_pulse", {15'd0, fruit_eaten}, 16'd1);
        chk("report_type", {8'd0, eaten_type}, {8'd0, et});
        chk("report_score", score, sc);
        frame_tail(8'd0, 0, 8'd0, 0);
    endtask

    // Hit in one frame, report at the next, then sit out the cooldown frames.
    task automatic do_hit(input logic [7:0] t);
        frame(t, 2, 8'd0, 0);
        cyc(1, 1, 0, 0, 0, 8'd0);
        frame_tail(8'd0, 0, 8'd0, 0);
        frame(8'd0, 0, 8'd0, 0);
        frame(8'd0, 0, 8'd0, 0);
    endtask

    initial begin
        resetN = 1'b0; startOfFrame = 0; game_active = 0; clear_score = 0;
        playerDrawRequest = 0; fruitDrawRequest = 0; fruit_type = 8'd0;
        model_reset();
        @(negedge clk); @(negedge clk);
        chk("rst_eaten", {15'd0, fruit_eaten}, 16'd0);
        chk("rst_type", {8'd0, eaten_type}, 16'd0);
        chk("rst_score", score, 16'd0);
        chk("rst_busy", {15'd0, busy}, 16'd0);
        resetN = 1'b1;

        // Basic hit, type 2; later-frame collisions during cooldown are ignored.
        frame(8'd2, 3, 8'd0, 0);
        cyc(1, 1, 0, 0, 0, 8'd0);
        chk("basic_pulse", {15'd0, fruit_eaten}, 16'd1);
        chk("basic_type", {8'd0, eaten_type}, 16'd2);
        chk("basic_score", score, 16'd20);
        chk("basic_busy", {15'd0, busy}, 16'd1);
        cyc(0, 1, 0, 0, 0, 8'd0);
        chk("pulse_one_cycle", {15'd0, fruit_eaten}, 16'd0);
        for (int i = 2; i < FL; i++) cyc(0, 1, 0, i == 3, i == 3, 8'd1);
        frame(8'd1, 2, 8'd0, 0);
        chk("cooldown_busy", {15'd0, busy}, 16'd1);
        // Re-armed this frame: types 3 then 1, first one wins.
        frame(8'd3, 2, 8'd1, 4);
        report_chk(8'd3, 16'd70);
        frame(8'd0, 0, 8'd0, 0);
        frame(8'd0, 0, 8'd0, 0);
        chk("rearmed_busy", {15'd0, busy}, 16'd0);

        // Collision on the frame-start pixel reports one frame later.
        cyc(1, 1, 0, 1, 1, 8'd2);
        chk("sof_col_nopulse", {15'd0, fruit_eaten}, 16'd0);
        chk("sof_col_busy", {15'd0, busy}, 16'd1);
        frame_tail(8'd0, 0, 8'd0, 0);
        report_chk(8'd2, 16'd90);
        frame(8'd0, 0, 8'd0, 0);
        frame(8'd0, 0, 8'd0, 0);

        // Type-0 overlap is not a collision.
        cyc(0, 1, 0, 1, 1, 8'd0);
        chk("type0_busy", {15'd0, busy}, 16'd0);

        // game_active drop discards a pending hit.
        cyc(0, 1, 0, 1, 1, 8'd4);
        chk("hit_busy", {15'd0, busy}, 16'd1);
        cyc(0, 0, 0, 0, 0, 8'd0);
        chk("ga_drop_busy", {15'd0, busy}, 16'd0);
        cyc(1, 1, 0, 0, 0, 8'd0);
        chk("ga_drop_nopulse", {15'd0, fruit_eaten}, 16'd0);
        chk("ga_drop_score", score, 16'd90);
        frame_tail(8'd0, 0, 8'd0, 0);

        // clear_score wins over a concurrent report addition.
        cyc(0, 1, 0, 1, 1, 8'd1);
        cyc(1, 1, 1, 0, 0, 8'd0);
        chk("clr_pulse", {15'd0, fruit_eaten}, 16'd1);
        chk("clr_type", {8'd0, eaten_type}, 16'd1);
        chk("clr_score", score, 16'd0);
        frame_tail(8'd0, 0, 8'd0, 0);
        frame(8'd0, 0, 8'd0, 0);
        frame(8'd0, 0, 8'd0, 0);

        // Reset during cooldown clears everything immediately.
        frame(8'd4, 1, 8'd0, 0);
        cyc(1, 1, 0, 0, 0, 8'd0);
        cyc(0, 1, 0, 0, 0, 8'd0);
        cyc(0, 1, 0, 0, 0, 8'd0);
        @(negedge clk);
        #2 resetN = 1'b0;
        #1;
        model_reset();
        chk("arst_eaten", {15'd0, fruit_eaten}, 16'd0);
        chk("arst_type", {8'd0, eaten_type}, 16'd0);
        chk("arst_score", score, 16'd0);
        chk("arst_busy", {15'd0, busy}, 16'd0);
        @(negedge clk);
        resetN = 1'b1;
        frame(8'd3, 2, 8'd0, 0);
        report_chk(8'd3, 16'd50);
        frame(8'd0, 0, 8'd0, 0);
        frame(8'd0, 0, 8'd0, 0);

        // Saturation: build 9990, then push past the ceiling.
        cyc(0, 1, 1, 0, 0, 8'd0);
        for (int i = 0; i < 99; i++) do_hit(8'd4);
        do_hit(8'd3);
        do_hit(8'd2);
        do_hit(8'd2);
        chk("preset_9990", score, 16'd9990);
        do_hit(8'd4);
        chk("sat_9999", score, 16'd9999);
        do_hit(8'd1);
        chk("sat_hold", score, 16'd9999);

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            cyc($urandom_range(0, 4) == 0, $urandom_range(0, 39) != 0,
                $urandom_range(0, 59) == 0, $urandom_range(0, 1) == 1,
                $urandom_range(0, 1) == 1, 8'($urandom_range(0, 5)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
